// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store controller for a word-organised data memory
//   CLK/RST_N : clock, synchronous active-low reset
//   req_*     : valid/ready request; size 00 byte, 01 half, 10 word, 11 illegal
//   resp_*    : one response per request; extended load data, error flag
//   M_*       : memory port, combinational read M_RD, synchronous write M_WE
module dmem_access_ctrl #(
    parameter int MEM_AW = 9
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] M_A,
    output logic [31:0] M_WD,
    output logic        M_WE,
    input  logic [31:0] M_RD
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state;
    logic        we, sgn, err, bad;
    logic [1:0]  size;
    logic [4:0]  sa;
    logic [31:0] addr, wd, rdata, sh, ld, mask, mg;
    always_comb begin
        bad  = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00) || req_addr[31:MEM_AW+2] != '0;
        sa   = {addr[1:0], 3'b000};
        sh   = M_RD >> sa;
        ld   = size == 2'b00 ? {{24{sgn & sh[7]}}, sh[7:0]} :
               size == 2'b01 ? {{16{sgn & sh[15]}}, sh[15:0]} : M_RD;
        // sub-word store: replace only the addressed lane of the sampled word
        mask = (size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sa;
        mg   = (M_RD & ~mask) | ((wd << sa) & mask);
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            we    <= 1'b0;
            sgn   <= 1'b0;
            size  <= 2'b00;
            addr  <= '0;
            wd    <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else case (state)
            IDLE: if (req_valid) begin
                we    <= req_we;
                size  <= req_size;
                sgn   <= req_signed;
                addr  <= req_addr;
                wd    <= req_wdata;
                rdata <= '0;
                err   <= bad;
                state <= bad ? RESP : (req_we && req_size == 2'b10) ? WR : RD;
            end
            RD: begin
                if (we) begin
                    wd    <= mg;
                    state <= WR;
                end else begin
                    rdata <= ld;
                    state <= RESP;
                end
            end
            WR: begin
                rdata <= '0;
                err   <= 1'b0;
                state <= RESP;
            end
            RESP: if (resp_ready) state <= IDLE;
        endcase
    end
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_rdata = rdata;
    assign resp_err   = err;
    assign M_A        = {addr[31:2], 2'b00};
    assign M_WD       = wd;
    // reset combinationally gates the write so a reset during WR drops it
    assign M_WE       = state == WR && RST_N;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized bench for dmem_access_ctrl against a byte-level memory model
module tb_dmem_access_ctrl;
    logic        CLK, RST_N;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, M_A, M_WD, M_RD;
    logic        M_WE;
    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];
    int          ncmp, nbad, wcnt;
    logic [31:0] wa, wdv;

    dmem_access_ctrl #(.MEM_AW(9)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .M_A(M_A), .M_WD(M_WD), .M_WE(M_WE), .M_RD(M_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign M_RD = mem[M_A[10:2]];
    always @(posedge CLK) if (M_WE) mem[M_A[10:2]] <= M_WD;
    always @(negedge CLK) if (M_WE) begin
        wcnt++;
        wa  = M_A;
        wdv = M_WD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rbyte(input logic [31:0] x);
        return ref_mem[x[10:2]][8*x[1:0] +: 8];
    endfunction

    task automatic wbyte(input logic [31:0] x, input logic [7:0] b);
        ref_mem[x[10:2]][8*x[1:0] +: 8] = b;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [63:0] v;
        logic [31:0] er;
        logic        ee;
        int          nb, el, lat, w0;
        nb = 1 << sz;
        ee = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a > 32'h7ff;
        el = ee ? 1 : (we && sz != 2'd2) ? 3 : 2;
        er = '0;
        if (!ee && !we) begin
            v = '0;
            for (int i = 0; i < nb; i++) v |= 64'(rbyte(a + 32'(i))) << (8 * i);
            if (sg && v[8*nb-1]) v |= {64{1'b1}} << (8 * nb);
            er = v[31:0];
        end
        if (!ee && we) for (int i = 0; i < nb; i++) wbyte(a + 32'(i), wd[8*i +: 8]);
        @(negedge CLK);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        w0 = wcnt;
        @(negedge CLK);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            chk("m_a_hold", M_A, {a[31:2], 2'b00});
            @(negedge CLK);
            lat++;
        end
        chk("latency", 32'(lat), 32'(el));
        chk("resp_err", 32'(resp_err), 32'(ee));
        chk("resp_rdata", resp_rdata, er);
        chk("busy_ready", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 2));
            req_addr = $urandom_range(0, 2047); req_wdata = $urandom;
            @(negedge CLK);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, er);
            chk("bp_err", 32'(resp_err), 32'(ee));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        chk("back_idle", 32'(req_ready), 32'd1);
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("write_count", 32'(wcnt - w0), 32'(we && !ee));
        if (we && !ee) begin
            chk("write_addr", wa, {a[31:2], 2'b00});
            chk("write_data", wdv, ref_mem[a[10:2]]);
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        ncmp = 0; nbad = 0; wcnt = 0; wa = '0; wdv = '0;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = $urandom;
            mem[i] = ref_mem[i];
        end
        RST_N = 1'b0; resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_ready", 32'(req_ready), 32'd1);
            chk("rst_valid", 32'(resp_valid), 32'd0);
            chk("rst_we", 32'(M_WE), 32'd0);
            chk("rst_ma", M_A, 32'd0);
            chk("rst_wd", M_WD, 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
        end
        req_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        chk("word_load", resp_rdata, 32'hDEADBEEF);
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0);
        xact(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 1);
        chk("rmw_word", wdv, 32'h1122AA44);
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 0);
        xact(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 0);
        xact(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 0);
        xact(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 0);
        xact(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
        xact(1'b1, 2'd2, 1'b0, 32'h13, 32'h55555555, 0);
        xact(1'b0, 2'd1, 1'b0, 32'h15, 32'h0, 0);
        xact(1'b0, 2'd0, 1'b0, 32'h800, 32'h0, 0);
        xact(1'b1, 2'd3, 1'b0, 32'h30, 32'hFFFFFFFF, 0);
        xact(1'b1, 2'd1, 1'b0, 32'hFFFF_FFF0, 32'h1234, 0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        xact(1'b1, 2'd1, 1'b0, 32'h7FE, 32'hBEEF, 5);

        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("wr_before_rst", 32'(M_WE), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("wr_rst_we", 32'(M_WE), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        chk("wr_rst_idle", 32'(req_ready), 32'd1);
        chk("wr_rst_valid", 32'(resp_valid), 32'd0);
        chk("wr_rst_ma", M_A, 32'd0);
        chk("wr_rst_mem", mem[16], ref_mem[16]);

        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
            a = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 2047));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                 $urandom_range(0, 3));
        end

        for (int i = 0; i < 512; i++) chk("mem_final", mem[i], ref_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
